// File: rtl/fm_sb_mon_arbiter_pkg.sv
// fm_sb_mon_arbiter_pkg: shared constants and types for the spy-buffer
// fast-monitoring arbiter (header layout, default sizing).
package fm_sb_mon_arbiter_pkg;

   localparam int sf_sb_n    = 3;
   localparam int mon_dw_max = 256;
   localparam int axi_dw     = 32;

   // One requester per spy buffer plus one extra monitor tap
   localparam int FM_SB_ARB_N_REQ = sf_sb_n + 1;

   localparam logic [7:0] FM_SB_ARB_HDR_MAGIC = 8'hA5;

   typedef struct packed {
      logic [7:0]  magic;
      logic [7:0]  src;
      logic [15:0] seq;
   } fm_sb_arb_hdr_t;

   // Number of output beats needed to carry one requester word
   function automatic int fm_sb_arb_beats(input int dw, input int out_dw);
      return dw / out_dw;
   endfunction

endpackage

// File: rtl/fm_sb_mon_arbiter_if.sv
// fm_sb_mon_arbiter_if: requester-side and stream-side signals of the
// monitor arbiter. slave = arbiter view, master = environment view.
interface fm_sb_mon_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DW     = 256,
   parameter int OUT_DW = 32,
   parameter int SRC_W  = $clog2(N_REQ)
);
   logic [N_REQ-1:0]    req_en;
   logic [N_REQ*DW-1:0] req_data;
   logic [N_REQ-1:0]    req_vld;
   logic [N_REQ-1:0]    req_rdy;
   logic [OUT_DW-1:0]   out_data;
   logic                out_vld;
   logic                out_last;
   logic [SRC_W-1:0]    out_src;
   logic                out_rdy;
   logic                busy;

   modport slave (
      input  req_en, req_data, req_vld, out_rdy,
      output req_rdy, out_data, out_vld, out_last, out_src, busy
   );

   modport master (
      output req_en, req_data, req_vld, out_rdy,
      input  req_rdy, out_data, out_vld, out_last, out_src, busy
   );
endinterface

// File: rtl/fm_sb_mon_arbiter_rr.sv
// fm_rr_arbiter: N-way combinational round-robin pick. The winner is the
// first requesting index above last_grant, wrapping modulo N.
module fm_rr_arbiter #(
   parameter int N  = 4,
   parameter int SW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] last_grant,
   output logic [SW-1:0] grant,
   output logic          any
);

   int idx;

   // Scan downward in distance so the closest request above last_grant wins
   always_comb begin
      grant = '0;
      any   = 1'b0;
      idx   = 0;
      for (int k = N; k >= 1; k--) begin
         idx = (int'(last_grant) + k) % N;
         if (req[idx]) begin
            grant = SW'(idx);
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fm_sb_mon_arbiter.sv
// fm_sb_mon_arbiter: round-robin arbiter that captures one monitor word
// from a granted requester and serialises it as OUT_DW-wide stream beats.
// Optional header beat {A5, src, seq} enabled by macro FM_SB_ARB_HDR_EN.
module fm_sb_mon_arbiter
   import fm_sb_mon_arbiter_pkg::*;
#(
   parameter int N_REQ  = FM_SB_ARB_N_REQ,
   parameter int DW     = mon_dw_max,
   parameter int OUT_DW = axi_dw
) (
   input  logic                  clk,
   input  logic                  rst,
   fm_sb_mon_arbiter_if.slave    bus
);

   localparam int SRC_W = $clog2(N_REQ);
   localparam int BEATS = fm_sb_arb_beats(DW, OUT_DW);
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
`ifdef FM_SB_ARB_HDR_EN
   localparam logic [1:0] ST_HDR  = 2'd2;
`endif

   if (DW % OUT_DW != 0) begin : g_dw_chk
      $error("fm_sb_mon_arbiter: DW must be a multiple of OUT_DW");
   end
`ifdef FM_SB_ARB_HDR_EN
   if (OUT_DW != 32) begin : g_hdr_chk
      $error("fm_sb_mon_arbiter: header beat requires OUT_DW == 32");
   end
`endif

   logic [1:0]       state_reg;
   logic [DW-1:0]    shift_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [SRC_W-1:0] src_reg;
   logic [SRC_W-1:0] last_grant_reg;
   logic [N_REQ-1:0] eligible;
   logic [SRC_W-1:0] winner;
   logic             win_any;
   logic             grant_fire;
   logic             last_beat;

   assign eligible   = bus.req_vld & bus.req_en;
   // Reset gates the capture strobe so no requester word is taken and lost
   assign grant_fire = (state_reg == ST_IDLE) && win_any && !rst;
   assign last_beat  = (cnt_reg == CNT_W'(BEATS - 1));

   fm_rr_arbiter #(.N(N_REQ), .SW(SRC_W)) u_rr (
      .req        (eligible),
      .last_grant (last_grant_reg),
      .grant      (winner),
      .any        (win_any)
   );

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rdy
      assign bus.req_rdy[gi] = grant_fire && (winner == SRC_W'(gi));
   end

`ifdef FM_SB_ARB_HDR_EN
   logic [15:0]    seq_reg;
   fm_sb_arb_hdr_t hdr;

   assign hdr = '{magic: FM_SB_ARB_HDR_MAGIC, src: 8'(src_reg), seq: seq_reg};

   // Message sequence number advances when the header beat is taken
   always_ff @(posedge clk) begin
      if (rst)
         seq_reg <= '0;
      else if (state_reg == ST_HDR && bus.out_rdy)
         seq_reg <= seq_reg + 16'd1;
   end
`endif

   // Grant/capture in IDLE, then shift the word out one beat per handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         shift_reg      <= '0;
         cnt_reg        <= '0;
         src_reg        <= '0;
         last_grant_reg <= SRC_W'(N_REQ - 1);
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (grant_fire) begin
                  shift_reg      <= bus.req_data[int'(winner)*DW +: DW];
                  src_reg        <= winner;
                  last_grant_reg <= winner;
                  cnt_reg        <= '0;
`ifdef FM_SB_ARB_HDR_EN
                  state_reg      <= ST_HDR;
`else
                  state_reg      <= ST_SEND;
`endif
               end
            end
`ifdef FM_SB_ARB_HDR_EN
            ST_HDR: begin
               if (bus.out_rdy)
                  state_reg <= ST_SEND;
            end
`endif
            ST_SEND: begin
               if (bus.out_rdy) begin
                  shift_reg <= shift_reg >> OUT_DW;
                  cnt_reg   <= cnt_reg + CNT_W'(1);
                  if (last_beat)
                     state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Stream outputs are pure functions of registered state, so they hold while stalled
   always_comb begin
      bus.out_vld  = (state_reg == ST_SEND);
      bus.out_data = '0;
      bus.out_last = (state_reg == ST_SEND) && last_beat;
      bus.out_src  = src_reg;
      bus.busy     = (state_reg != ST_IDLE);
      if (state_reg == ST_SEND)
         bus.out_data = shift_reg[OUT_DW-1:0];
`ifdef FM_SB_ARB_HDR_EN
      if (state_reg == ST_HDR) begin
         bus.out_vld  = 1'b1;
         bus.out_data = OUT_DW'(hdr);
      end
`endif
   end

endmodule
